// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller: FSM states and
// EX forwarding-mux select encodings.
package hazard_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        MWAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: register indices and enables in,
// stall/flush/forward controls and status out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE;
    logic             MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE_zero, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_perf_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: boot hold, data-memory wait FSM with timeout,
// load-use / branch / memory stall-flush priority, EX forwarding, perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input logic           clk,
    input logic           reset,
    hazard_ctrl_if.slave  bus
);

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);

    state_t        state, state_nxt;
    logic [BW-1:0] boot_cnt, boot_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          mem_err_q, err_nxt;
    logic          lw_stall, mem_stall, in_run;
    logic          stall_f, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, flush_w;

    assign lw_stall  = bus.ResultSrcE_zero && (bus.RdE != 5'd0) &&
                       ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
    assign mem_stall = bus.MemReqM && !bus.MemReadyM;
    assign in_run    = (state != BOOT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= BOOT;
            boot_cnt  <= '0;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            boot_cnt  <= boot_nxt;
            wait_cnt  <= wait_nxt;
            mem_err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        boot_nxt  = boot_cnt;
        wait_nxt  = wait_cnt;
        case (state)
            BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    state_nxt = RUN;
                    boot_nxt  = '0;
                end else begin
                    boot_nxt = boot_cnt + 1'b1;
                end
            end
            RUN: begin
                if (mem_stall) begin
                    state_nxt = MWAIT;
                    wait_nxt  = WW'(1);
                end
            end
            MWAIT: begin
                // Ready completes the access; a dropped request is illegal but
                // must not leave the pipeline frozen, so both return to RUN.
                if (mem_stall) begin
                    if (wait_cnt != WAIT_MAX) wait_nxt = wait_cnt + 1'b1;
                end else begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            end
            default: begin
                state_nxt = BOOT;
                boot_nxt  = '0;
                wait_nxt  = '0;
            end
        endcase
        err_nxt = mem_err_q || (in_run && mem_stall && (wait_nxt == WAIT_MAX));
    end

    // Mealy stall/flush decode; memory wait defers a pending branch redirect.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (!in_run) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (bus.PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        bus.ForwardAE = FWD_RF;
        if (bus.RegWriteM && (bus.RdM != 5'd0) && (bus.RdM == bus.Rs1E))
            bus.ForwardAE = FWD_M;
        else if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == bus.Rs1E))
            bus.ForwardAE = FWD_W;
    end

    always_comb begin
        bus.ForwardBE = FWD_RF;
        if (bus.RegWriteM && (bus.RdM != 5'd0) && (bus.RdM == bus.Rs2E))
            bus.ForwardBE = FWD_M;
        else if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == bus.Rs2E))
            bus.ForwardBE = FWD_W;
    end

    assign bus.StallF  = stall_f;
    assign bus.StallD  = stall_d;
    assign bus.StallE  = stall_e;
    assign bus.StallM  = stall_m;
    assign bus.FlushD  = flush_d;
    assign bus.FlushE  = flush_e;
    assign bus.FlushW  = flush_w;
    assign bus.mem_err = mem_err_q;

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_run && stall_f),
        .count (bus.stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_run && !mem_stall && bus.PCSrcE),
        .count (bus.flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed plan sequences then random
// traffic, checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int BOOT  = 4;
    localparam int TO    = 8;
    localparam int CW    = 5;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct {
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       ld, wem, wew, pcsrc, req, rdy;
    } stim_t;

    typedef struct {
        logic [3:0] stall;
        logic [2:0] flush;
        logic [1:0] fa, fb;
        logic       err;
        int         sc, fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) bus ();

    hazard_ctrl #(.BOOT_CYCLES(BOOT), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exq[$];
    int   total = 0;
    int   passed = 0;

    // Model state
    int boot_left = BOOT;
    bit waiting   = 0;
    int waited    = 0;
    bit err_m     = 0;
    int sc_m      = 0;
    int fc_m      = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs, input logic [4:0] rdm,
                                       input logic wem, input logic [4:0] rdw, input logic wew);
        if (wem && rdm != 0 && rdm == rs) return 2'b10;
        if (wew && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst:1'b0, rs1d:5'd0, rs2d:5'd0, rs1e:5'd0, rs2e:5'd0, rde:5'd0, rdm:5'd0,
              rdw:5'd0, ld:1'b0, wem:1'b0, wew:1'b0, pcsrc:1'b0, req:1'b0, rdy:1'b0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   ms, lw;
        @(negedge clk);
        reset = s.rst;
        bus.Rs1D = s.rs1d; bus.Rs2D = s.rs2d; bus.Rs1E = s.rs1e; bus.Rs2E = s.rs2e;
        bus.RdE = s.rde; bus.RdM = s.rdm; bus.RdW = s.rdw;
        bus.ResultSrcE_zero = s.ld; bus.RegWriteM = s.wem; bus.RegWriteW = s.wew;
        bus.PCSrcE = s.pcsrc; bus.MemReqM = s.req; bus.MemReadyM = s.rdy;
        if (s.rst) begin
            boot_left = BOOT; waiting = 0; waited = 0; err_m = 0; sc_m = 0; fc_m = 0;
        end
        ms = s.req && !s.rdy;
        lw = s.ld && s.rde != 0 && (s.rde == s.rs1d || s.rde == s.rs2d);
        e.fa = fwd(s.rs1e, s.rdm, s.wem, s.rdw, s.wew);
        e.fb = fwd(s.rs2e, s.rdm, s.wem, s.rdw, s.wew);
        e.err = err_m; e.sc = sc_m; e.fc = fc_m;
        if (boot_left > 0)  begin e.stall = 4'b1000; e.flush = 3'b110; end
        else if (ms)        begin e.stall = 4'b1111; e.flush = 3'b001; end
        else if (s.pcsrc)   begin e.stall = 4'b0000; e.flush = 3'b110; end
        else if (lw)        begin e.stall = 4'b1100; e.flush = 3'b010; end
        else                begin e.stall = 4'b0000; e.flush = 3'b000; end
        exq.push_back(e);
        if (!s.rst) begin
            if (boot_left > 0) begin
                boot_left--;
            end else begin
                if (e.stall[3] && sc_m < CMAX) sc_m++;
                if (!ms && s.pcsrc && fc_m < CMAX) fc_m++;
                if (!waiting) begin
                    if (ms) begin waiting = 1; waited = 1; end
                end else if (ms) begin
                    if (waited < TO) waited++;
                end else begin
                    waiting = 0; waited = 0;
                end
                if (waiting && waited >= TO) err_m = 1;
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exq.size() > 0) begin
                e = exq.pop_front();
                chk("stall{F,D,E,M}", int'({bus.StallF, bus.StallD, bus.StallE, bus.StallM}), int'(e.stall));
                chk("flush{D,E,W}", int'({bus.FlushD, bus.FlushE, bus.FlushW}), int'(e.flush));
                chk("ForwardAE", int'(bus.ForwardAE), int'(e.fa));
                chk("ForwardBE", int'(bus.ForwardBE), int'(e.fb));
                chk("mem_err", int'(bus.mem_err), int'(e.err));
                chk("stall_cnt", int'(bus.stall_cnt), e.sc);
                chk("flush_cnt", int'(bus.flush_cnt), e.fc);
            end
        end
    end

    initial begin
        stim_t s;
        s = idle(); s.rst = 1'b1;
        step(s); step(s);
        // Boot hold, with forwarding exercised during it
        s = idle(); s.rdm = 5'd3; s.wem = 1'b1; s.rs1e = 5'd3;
        repeat (BOOT + 2) step(s);
        // Forwarding priority
        s = idle(); s.rdm = 5'd5; s.wem = 1'b1; s.rdw = 5'd5; s.wew = 1'b1; s.rs1e = 5'd5;
        step(s);
        s.rdm = 5'd0; step(s);
        s.rs2e = 5'd5; s.rs1e = 5'd0; step(s);
        // Load-use
        s = idle(); s.ld = 1'b1; s.rde = 5'd7; s.rs2d = 5'd7; step(s);
        step(idle());
        // Branch wins over load-use
        s.pcsrc = 1'b1; step(s);
        step(idle());
        // Memory wait with deferred branch
        s = idle(); s.req = 1'b1; s.pcsrc = 1'b1;
        repeat (3) step(s);
        s.rdy = 1'b1; step(s);
        step(idle());
        // Timeout, then reset mid-wait
        s = idle(); s.req = 1'b1;
        repeat (12) step(s);
        s.rst = 1'b1; step(s);
        s = idle();
        repeat (BOOT + 2) step(s);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            s.rst   = ($urandom_range(0, 199) == 0);
            s.rs1d  = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
            s.rs1e  = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
            s.rde   = 5'($urandom_range(0, 3)); s.rdm  = 5'($urandom_range(0, 3));
            s.rdw   = 5'($urandom_range(0, 3));
            s.ld    = ($urandom_range(0, 3) == 0);
            s.wem   = 1'($urandom); s.wew = 1'($urandom);
            s.pcsrc = ($urandom_range(0, 6) == 0);
            s.req   = ($urandom_range(0, 2) == 0);
            s.rdy   = ($urandom_range(0, 4) < 2);
            step(s);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drain", exq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
